// File: rtl/mips_defs_pkg.sv
// mips_defs_pkg: opcode constants, MEM-stage FSM states, access sizes and byte-enable codes.
package mips_defs_pkg;
  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;
  typedef enum logic {ST_IDLE, ST_WAIT} state_t;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} acc_size_t;
  function automatic acc_size_t op_size(input logic [5:0] op);
    return (op == OP_LB || op == OP_LBU || op == OP_SB) ? SZ_BYTE :
           (op == OP_LH || op == OP_LHU || op == OP_SH) ? SZ_HALF : SZ_WORD;
  endfunction
endpackage

// File: rtl/load_store_align.sv
// load_store_align: store byte-enables and lane replication, load lane extraction with sign/zero extension.
module load_store_align
  import mips_defs_pkg::*;
(
  input  logic [5:0]  i_opcode,
  input  logic [1:0]  i_addr,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_load
);
  acc_size_t   w_size;
  logic        w_sext;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  always_comb begin
    w_size  = op_size(i_opcode);
    w_sext  = i_opcode != OP_LBU && i_opcode != OP_LHU;
    w_byte  = i_rdata[{i_addr, 3'b000} +: 8];
    w_half  = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];
    o_be    = w_size == SZ_BYTE ? BE_BYTE0 << i_addr :
              w_size == SZ_HALF ? (i_addr[1] ? BE_HALF_HI : BE_HALF_LO) : BE_WORD;
    o_wdata = w_size == SZ_BYTE ? {4{i_wdata[7:0]}} :
              w_size == SZ_HALF ? {2{i_wdata[15:0]}} : i_wdata;
    o_load  = w_size == SZ_BYTE ? {{24{w_sext & w_byte[7]}}, w_byte} :
              w_size == SZ_HALF ? {{16{w_sext & w_half[15]}}, w_half} : i_rdata;
  end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: MIPS memory-access stage with req/ack data port, alignment, branch resolve and MEM/WB register.
// Define MEM_TIMEOUT_EN to abort accesses unacknowledged for TIMEOUT cycles and pulse bus_err_out.
module mem_stage
  import mips_defs_pkg::*;
#(
  parameter int B = 32,
  parameter int W = 5
`ifdef MEM_TIMEOUT_EN
  , parameter int TIMEOUT = 16
`endif
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [B-1:0] add_result_in,
  input  logic [B-1:0] pc_jump_in,
  input  logic [B-1:0] alu_result_in,
  input  logic [B-1:0] r_data2_in,
  input  logic [W-1:0] mux_RegDst_in,
  input  logic         zero_in,
  input  logic         wb_RegWrite_in,
  input  logic         wb_MemtoReg_in,
  input  logic         m_Jump_in,
  input  logic         m_Branch_in,
  input  logic         m_BranchNot_in,
  input  logic         m_MemRead_in,
  input  logic         m_MemWrite_in,
  input  logic [5:0]   opcode_in,
  output logic         dmem_req,
  output logic         dmem_we,
  output logic [B-1:0] dmem_addr,
  output logic [B-1:0] dmem_wdata,
  output logic [3:0]   dmem_be,
  input  logic         dmem_ack,
  input  logic [B-1:0] dmem_rdata,
  output logic         mem_stall,
  output logic         pc_src,
  output logic [B-1:0] pc_target,
  output logic [B-1:0] read_data_out,
  output logic [B-1:0] alu_result_out,
  output logic [W-1:0] mux_RegDst_out,
  output logic         wb_RegWrite_out,
  output logic         wb_MemtoReg_out,
  output logic         misalign_out
`ifdef MEM_TIMEOUT_EN
  , output logic       bus_err_out
`endif
);
  state_t      r_state, w_next;
  acc_size_t   w_size;
  logic        w_misalign, w_access, w_done, w_fail, w_bubble;
  logic [3:0]  w_be;
  logic [31:0] w_wdata, w_load;
  load_store_align u_align (
    .i_opcode(opcode_in),
    .i_addr  (alu_result_in[1:0]),
    .i_wdata (r_data2_in),
    .i_rdata (dmem_rdata),
    .o_be    (w_be),
    .o_wdata (w_wdata),
    .o_load  (w_load)
  );
  // WAIT keeps the access alive on its own so only reset or ack/timeout can end it
  always_comb begin
    w_size     = op_size(opcode_in);
    w_misalign = (m_MemRead_in | m_MemWrite_in) &
                 ((w_size == SZ_HALF & alu_result_in[0]) | (w_size == SZ_WORD & |alu_result_in[1:0]));
    w_access   = reset & (r_state == ST_WAIT | ((m_MemRead_in | m_MemWrite_in) & ~w_misalign));
    w_done     = w_access & dmem_ack;
    mem_stall  = w_access & ~dmem_ack & ~w_fail;
    w_bubble   = mem_stall | w_fail;
    w_next     = mem_stall ? ST_WAIT : ST_IDLE;
    dmem_req   = w_access;
    dmem_we    = w_access & m_MemWrite_in;
    dmem_addr  = {alu_result_in[B-1:2], 2'b00};
    dmem_wdata = w_wdata;
    dmem_be    = w_access ? w_be : 4'b0000;
    pc_src     = m_Jump_in | (m_Branch_in & zero_in) | (m_BranchNot_in & ~zero_in);
    pc_target  = m_Jump_in ? pc_jump_in : add_result_in;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state         <= ST_IDLE;
      read_data_out   <= '0;
      alu_result_out  <= '0;
      mux_RegDst_out  <= '0;
      wb_RegWrite_out <= 1'b0;
      wb_MemtoReg_out <= 1'b0;
      misalign_out    <= 1'b0;
    end else begin
      r_state         <= w_next;
      read_data_out   <= (~w_bubble & m_MemRead_in & w_done) ? w_load : '0;
      alu_result_out  <= w_bubble ? '0 : alu_result_in;
      mux_RegDst_out  <= w_bubble ? '0 : mux_RegDst_in;
      wb_RegWrite_out <= ~w_bubble & wb_RegWrite_in & ~w_misalign;
      wb_MemtoReg_out <= ~w_bubble & wb_MemtoReg_in & ~w_misalign;
      misalign_out    <= ~w_bubble & w_misalign;
    end
  end
`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT);
  logic [CW-1:0] r_cnt;
  // counts req cycles; the issue cycle is 0, so the TIMEOUT-th req cycle aborts
  assign w_fail = r_state == ST_WAIT && !dmem_ack && r_cnt == CW'(TIMEOUT - 1);
  always_ff @(posedge clk) begin
    r_cnt       <= (!reset || w_next == ST_IDLE) ? '0 : r_cnt + 1'b1;
    bus_err_out <= reset & w_fail;
  end
`else
  assign w_fail = 1'b0;
`endif
endmodule
